// File: rtl/fwd_pkg.sv
// Forwarding scoreboard shared types: in-flight entry record,
// select-width derivation and operand select encodings.
package fwd_pkg;

    // Widest register address an entry can hold; narrower
    // addresses are zero-extended into the entry.
    localparam int FWD_MAX_ADDR_W = 8;

    // Operand select encodings (s = EX-relative source stage).
    localparam int FWD_SEL_RF    = 0;
    localparam int FWD_SEL_EXMEM = 1;
    localparam int FWD_SEL_MEMWB = 2;

    typedef struct packed {
        logic                      valid;
        logic                      isLoad;
        logic [FWD_MAX_ADDR_W-1:0] rd;
    } fwdEntry_t;

    function automatic int fwdSelW(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Youngest-producer match for one source operand.
// Ports: srcAddr/srcUsed in, entries in, sel/loadHazard out.
module fwd_match
    import fwd_pkg::*;
#(
    parameter int ADDR_W   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    parameter int SEL_W    = 2
) (
    input  logic [ADDR_W-1:0]     srcAddr,
    input  logic                  srcUsed,
    input  fwdEntry_t [DEPTH-1:0] entries,
    output logic [SEL_W-1:0]      sel,
    output logic                  loadHazard
);

    logic [FWD_MAX_ADDR_W-1:0] addrExt;

    assign addrExt = FWD_MAX_ADDR_W'(srcAddr);

    // Walk oldest to youngest so the youngest hit overrides.
    always_comb begin
        sel        = SEL_W'(FWD_SEL_RF);
        loadHazard = 1'b0;
        if (srcUsed && (srcAddr != '0)) begin
            for (int k = DEPTH - 1; k >= 0; k--) begin
                if (entries[k].valid && (entries[k].rd == addrExt)) begin
                    // WB producer writes before the regfile read.
                    sel = (k == DEPTH - 1) ? SEL_W'(FWD_SEL_RF)
                                           : SEL_W'(k + 1);
                    loadHazard = entries[k].isLoad
                               && ((k + 1) < LOAD_LAT);
                end
            end
        end
    end

endmodule

// File: rtl/forward_scoreboard.sv
// Forwarding scoreboard: tracks in-flight writers after ID, drives
// registered EX operand selects and a combinational load-use stall.
// Ports: clk_i, rst_i (async, active-low), id_* instruction fields,
// flush_i, stall_o, ex_fwd_sel_o; stall_cnt_o with FWD_STALL_CNT_EN.
module forward_scoreboard
    import fwd_pkg::*;
#(
    parameter  int ADDR_W   = 5,
    parameter  int NUM_SRC  = 2,
    parameter  int DEPTH    = 3,
    parameter  int LOAD_LAT = 2,
    localparam int SEL_W    = fwdSelW(DEPTH)
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      id_valid_i,
    input  logic [NUM_SRC*ADDR_W-1:0] id_src_addr_i,
    input  logic [NUM_SRC-1:0]        id_src_used_i,
    input  logic [ADDR_W-1:0]         id_rd_addr_i,
    input  logic                      id_reg_write_i,
    input  logic                      id_is_load_i,
    input  logic                      flush_i,
    output logic                      stall_o,
    output logic [NUM_SRC*SEL_W-1:0]  ex_fwd_sel_o
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [31:0]               stall_cnt_o
`endif
);

    fwdEntry_t [DEPTH-1:0]      entries;
    fwdEntry_t                  newEntry;
    logic [NUM_SRC-1:0]         srcHazard;
    logic [NUM_SRC*SEL_W-1:0]   selNext;
    logic                       issue;

    for (genvar i = 0; i < NUM_SRC; i++) begin : gSrc
        fwd_match #(
            .ADDR_W  (ADDR_W),
            .DEPTH   (DEPTH),
            .LOAD_LAT(LOAD_LAT),
            .SEL_W   (SEL_W)
        ) uMatch (
            .srcAddr   (id_src_addr_i[i*ADDR_W +: ADDR_W]),
            .srcUsed   (id_src_used_i[i]),
            .entries   (entries),
            .sel       (selNext[i*SEL_W +: SEL_W]),
            .loadHazard(srcHazard[i])
        );
    end

    // Flush wins over stall; reset forces the stall low at once.
    assign stall_o = rst_i && id_valid_i && !flush_i && (|srcHazard);
    assign issue   = id_valid_i && !stall_o && !flush_i;

    always_comb begin
        newEntry        = '0;
        newEntry.valid  = issue && id_reg_write_i
                        && (id_rd_addr_i != '0);
        newEntry.isLoad = id_is_load_i;
        newEntry.rd     = FWD_MAX_ADDR_W'(id_rd_addr_i);
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            entries      <= '0;
            ex_fwd_sel_o <= '0;
        end else begin
            entries[0] <= newEntry;
            for (int k = 1; k < DEPTH; k++) begin
                entries[k] <= entries[k-1];
            end
            ex_fwd_sel_o <= issue ? selNext : '0;
        end
    end

`ifdef FWD_STALL_CNT_EN
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            stall_cnt_o <= '0;
        end else if (stall_o && (stall_cnt_o != '1)) begin
            stall_cnt_o <= stall_cnt_o + 32'd1;
        end
    end
`endif

endmodule
